// File: rtl/matrix_serializer.sv
// Streams a captured m x n matrix one element per valid/ready transfer, row-major by default.
// Defining MATRIX_SER_TRANSPOSE_EN adds a transpose input that selects column-major order.
module matrix_serializer #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                m,
  input  logic [2:0]                n,
  input  logic [DIM*DIM*ELEM_W-1:0] matrix,
`ifdef MATRIX_SER_TRANSPOSE_EN
  input  logic                      transpose,
`endif
  input  logic                      elemReady,
  output logic                      elemValid,
  output logic [ELEM_W-1:0]         elemData,
  output logic [2:0]                elemRow,
  output logic [2:0]                elemCol,
  output logic                      elemLast,
  output logic                      rowLast,
  output logic                      busy,
  output logic                      done,
  output logic                      dimError
);

  localparam int IDX_W = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                      state_q, state_d;
  logic [DIM*DIM*ELEM_W-1:0]   mat_q, mat_d;
  logic [2:0]                  m_q, m_d, n_q, n_d;
  logic [2:0]                  row_q, row_d, col_q, col_d;
  logic                        col_major;
  logic                        dims_ok;
  logic                        end_row, end_col;
  logic [IDX_W-1:0]            idx;
  logic [ELEM_W-1:0]           elems [DIM*DIM];

`ifdef MATRIX_SER_TRANSPOSE_EN
  logic tr_q, tr_d;
  assign col_major = tr_q;
`else
  assign col_major = 1'b0;
`endif

  assign dims_ok = (m != 3'd0) && (int'(m) <= DIM) && (n != 3'd0) && (int'(n) <= DIM);
  assign end_row = (row_q == m_q - 3'd1);
  assign end_col = (col_q == n_q - 3'd1);
  assign idx     = IDX_W'(row_q) * IDX_W'(DIM) + IDX_W'(col_q);

  always_comb begin
    for (int k = 0; k < DIM * DIM; k++) begin
      elems[k] = mat_q[k*ELEM_W +: ELEM_W];
    end
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
`ifdef MATRIX_SER_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && dims_ok) begin
          mat_d   = matrix;
          m_d     = m;
          n_d     = n;
          row_d   = 3'd0;
          col_d   = 3'd0;
`ifdef MATRIX_SER_TRANSPOSE_EN
          tr_d    = transpose;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (elemReady) begin
          if (end_row && end_col) begin
            state_d = DONE;
          end else if (col_major) begin
            if (end_row) begin
              row_d = 3'd0;
              col_d = col_q + 3'd1;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            if (end_col) begin
              col_d = 3'd0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element outputs are gated so they read zero whenever no element is offered.
  always_comb begin
    elemValid = 1'b0;
    elemData  = '0;
    elemRow   = 3'd0;
    elemCol   = 3'd0;
    elemLast  = 1'b0;
    rowLast   = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dimError  = !reset && (state_q == IDLE) && start && !dims_ok;
    if (state_q == SEND) begin
      elemValid = 1'b1;
      elemData  = elems[idx];
      elemRow   = row_q;
      elemCol   = col_q;
      elemLast  = end_row && end_col;
      rowLast   = col_major ? end_row : end_col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mat_q   <= '0;
      m_q     <= 3'd0;
      n_q     <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
`ifdef MATRIX_SER_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
`ifdef MATRIX_SER_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_serializer.sv
// Directed bench for matrix_serializer: reset, streaming, stalls, dimension errors, abort, start-ignore.
module tb_matrix_serializer;
  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int MW     = DIM * DIM * ELEM_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        m, n;
  logic [MW-1:0]     matrix;
  logic              elemReady;
`ifdef MATRIX_SER_TRANSPOSE_EN
  logic              transpose;
`endif
  logic              elemValid;
  logic [ELEM_W-1:0] elemData;
  logic [2:0]        elemRow, elemCol;
  logic              elemLast, rowLast, busy, done, dimError;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  matrix_serializer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m         (m),
    .n         (n),
    .matrix    (matrix),
`ifdef MATRIX_SER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .elemReady (elemReady),
    .elemValid (elemValid),
    .elemData  (elemData),
    .elemRow   (elemRow),
    .elemCol   (elemCol),
    .elemLast  (elemLast),
    .rowLast   (rowLast),
    .busy      (busy),
    .done      (done),
    .dimError  (dimError)
  );

  // Element (i,j) = base + 10*i + j over the full DIM x DIM grid.
  function automatic logic [MW-1:0] mk_matrix(input int base);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r[(i*DIM+j)*ELEM_W +: ELEM_W] = ELEM_W'(base + 10*i + j);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int mm, input int nn, input int base, input bit tr);
    start  = 1'b1;
    m      = 3'(mm);
    n      = 3'(nn);
    matrix = mk_matrix(base);
`ifdef MATRIX_SER_TRANSPOSE_EN
    transpose = tr;
`else
    if (tr) $display("note: transpose requested in a build without it");
`endif
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; elemReady = 1'b1;
    m = 3'd0; n = 3'd0; matrix = '0;
`ifdef MATRIX_SER_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    step();
    start = 1'b1; m = 3'd2; n = 3'd2; matrix = mk_matrix(0);
    @(negedge clk);
    vectors++;
    if ({elemValid, elemData, elemRow, elemCol, elemLast, rowLast, busy, done, dimError} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0",
               {elemValid, elemData, elemRow, elemCol, elemLast, rowLast, busy, done, dimError});
    end
    step();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || elemValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_priority: busy=%b elemValid=%b required 0 0", busy, elemValid);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int exp_d;
    elemReady = 1'b1;
    issue_start(2, 3, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      exp_d = 10*(k/3) + (k%3);
      @(negedge clk);
      vectors++;
      if (elemValid !== 1'b1 || elemData !== ELEM_W'(exp_d) || elemRow !== 3'(k/3) || elemCol !== 3'(k%3)
          || rowLast !== ((k%3) == 2) || elemLast !== (k == 5)) begin
        miscompares++;
        $display("FAIL basic_elem%0d: got v=%b d=%0d r=%0d c=%0d rl=%b el=%b required v=1 d=%0d r=%0d c=%0d rl=%b el=%b",
                 k, elemValid, elemData, elemRow, elemCol, rowLast, elemLast,
                 exp_d, k/3, k%3, (k%3) == 2, k == 5);
      end
      step();
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || elemValid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: done=%b elemValid=%b busy=%b required 1 0 1", done, elemValid, busy);
    end
    step();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy);
    end
    step();
  endtask

  task automatic test_stall();
    int cnt, exp_d;
    bit prev_last, seen_done;
    cnt = 0; prev_last = 1'b0; seen_done = 1'b0;
    elemReady = 1'b1;
    issue_start(5, 5, 0, 1'b0);
    for (int c = 0; c < 120 && !seen_done; c++) begin
      elemReady = (c % 2 == 0);
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        vectors++;
        if (!(prev_last && cnt == 25)) begin
          miscompares++;
          $display("FAIL stall_done: transfers=%0d last_prev=%b required 25 1", cnt, prev_last);
        end
      end else begin
        prev_last = 1'b0;
        vectors++;
        exp_d = 10*(cnt/5) + (cnt%5);
        if (elemValid !== 1'b1 || elemData !== ELEM_W'(exp_d) || elemRow !== 3'(cnt/5)
            || elemCol !== 3'(cnt%5) || elemLast !== (cnt == 24)) begin
          miscompares++;
          $display("FAIL stall_elem%0d: got v=%b d=%0d r=%0d c=%0d el=%b required v=1 d=%0d el=%b",
                   cnt, elemValid, elemData, elemRow, elemCol, elemLast, exp_d, cnt == 24);
        end
        if (elemReady) begin
          if (cnt == 24) prev_last = 1'b1;
          cnt++;
        end
      end
      step();
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_timeout: transfers=%0d required done after 25", cnt);
    end
    elemReady = 1'b1;
    step();
  endtask

  task automatic test_dim_error();
    int mm [2] = '{0, 6};
    int nn [2] = '{3, 2};
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; m = 3'(mm[t]); n = 3'(nn[t]); matrix = mk_matrix(0);
      @(negedge clk);
      vectors++;
      if (dimError !== 1'b1 || busy !== 1'b0 || elemValid !== 1'b0) begin
        miscompares++;
        $display("FAIL dimerr_pulse m=%0d n=%0d: dimError=%b busy=%b v=%b required 1 0 0",
                 mm[t], nn[t], dimError, busy, elemValid);
      end
      step();
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if (dimError !== 1'b0 || busy !== 1'b0 || elemValid !== 1'b0) begin
        miscompares++;
        $display("FAIL dimerr_after m=%0d n=%0d: dimError=%b busy=%b v=%b required 0 0 0",
                 mm[t], nn[t], dimError, busy, elemValid);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int exp_d;
    elemReady = 1'b1;
    issue_start(3, 3, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_d = 10*(k/3) + (k%3);
      @(negedge clk);
      vectors++;
      if (elemValid !== 1'b1 || elemData !== ELEM_W'(exp_d)) begin
        miscompares++;
        $display("FAIL abort_elem%0d: got v=%b d=%0d required v=1 d=%0d", k, elemValid, elemData, exp_d);
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({elemValid, elemData, elemRow, elemCol, elemLast, rowLast, busy, done, dimError} !== 20'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h required 0",
               {elemValid, elemData, elemRow, elemCol, elemLast, rowLast, busy, done, dimError});
    end
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_done%0d: done=%b busy=%b required 0 0", c, done, busy);
      end
    end
    step();
    issue_start(1, 1, 77, 1'b0);
    @(negedge clk);
    vectors++;
    if (elemValid !== 1'b1 || elemData !== 8'd77 || elemLast !== 1'b1 || rowLast !== 1'b1
        || elemRow !== 3'd0 || elemCol !== 3'd0) begin
      miscompares++;
      $display("FAIL one_by_one: v=%b d=%0d el=%b rl=%b r=%0d c=%0d required 1 77 1 1 0 0",
               elemValid, elemData, elemLast, rowLast, elemRow, elemCol);
    end
    step();
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || elemValid !== 1'b0) begin
      miscompares++;
      $display("FAIL one_by_one_done: done=%b v=%b required 1 0", done, elemValid);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int exp_d;
    elemReady = 1'b1;
    issue_start(2, 3, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        start = 1'b1; m = 3'd5; n = 3'd5; matrix = mk_matrix(100);
      end else begin
        start = 1'b0;
      end
      exp_d = 10*(k/3) + (k%3);
      @(negedge clk);
      vectors++;
      if (elemValid !== 1'b1 || elemData !== ELEM_W'(exp_d) || elemLast !== (k == 5)) begin
        miscompares++;
        $display("FAIL ignore_elem%0d: got v=%b d=%0d el=%b required v=1 d=%0d el=%b",
                 k, elemValid, elemData, elemLast, exp_d, k == 5);
      end
      step();
    end
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || elemValid !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_done: done=%b v=%b required 1 0", done, elemValid);
    end
    step();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || elemValid !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_in_done: busy=%b v=%b required 0 0", busy, elemValid);
    end
    step();
  endtask

`ifdef MATRIX_SER_TRANSPOSE_EN
  task automatic test_transpose();
    int exp_d;
    elemReady = 1'b1;
    issue_start(2, 3, 0, 1'b1);
    transpose = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_d = 10*(k%2) + (k/2);
      @(negedge clk);
      vectors++;
      if (elemValid !== 1'b1 || elemData !== ELEM_W'(exp_d) || elemRow !== 3'(k%2) || elemCol !== 3'(k/2)
          || rowLast !== ((k%2) == 1) || elemLast !== (k == 5)) begin
        miscompares++;
        $display("FAIL transpose_elem%0d: got d=%0d r=%0d c=%0d rl=%b el=%b required d=%0d r=%0d c=%0d rl=%b el=%b",
                 k, elemData, elemRow, elemCol, rowLast, elemLast,
                 exp_d, k%2, k/2, (k%2) == 1, k == 5);
      end
      step();
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL transpose_done: done=%b required 1", done);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_dim_error();
    test_reset_mid();
    test_start_ignored();
`ifdef MATRIX_SER_TRANSPOSE_EN
    test_transpose();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_serializer.md
MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 The block SHALL have parameter DIM, default 5, giving the maximum rows/columns per matrix.
REQ-002 The block SHALL have parameter ELEM_W, default 8, giving the element width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request to serialize the matrix presented this cycle.
REQ-007 m  in  3  row count, valid range 1..DIM.
REQ-008 n  in  3  column count, valid range 1..DIM.
REQ-009 matrix  in  DIM*DIM*ELEM_W  packed matrix; element (i,j) at bits [(i*DIM+j)*ELEM_W +: ELEM_W].
REQ-010 elemReady  in  1  downstream accepts the current element.
REQ-011 elemValid  out  1  elemData/elemRow/elemCol/elemLast/rowLast are valid.
REQ-012 elemData  out  ELEM_W  current element value.
REQ-013 elemRow, elemCol  out  3 each  zero-based index of the current element.
REQ-014 elemLast  out  1  current element is the final element of the matrix.
REQ-015 rowLast  out  1  current element is the final element of its row (col == n-1).
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 done  out  1  one-cycle pulse after the final transfer.
REQ-018 dimError  out  1  one-cycle pulse on start with an illegal m or n.

Function
REQ-019 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-020 IDLE: on start with 1<=m<=DIM and 1<=n<=DIM, the block SHALL register matrix, m and n, clear row/col to 0 and enter SEND at the next edge.
REQ-021 IDLE: on start with m or n equal to 0 or greater than DIM, the block SHALL pulse dimError for one cycle and remain in IDLE.
REQ-022 Latency: start accepted in cycle T SHALL give elemValid=1 for element (0,0) in cycle T+1.
REQ-023 A transfer SHALL occur on any cycle with elemValid && elemReady.
REQ-024 While elemValid && !elemReady, all element outputs SHALL hold stable.
REQ-025 Default order SHALL be row-major: col increments; at col==n-1, col resets to 0 and row increments.
REQ-026 On the transfer with row==m-1 and col==n-1 (elemLast=1), the block SHALL enter DONE and drop elemValid in the next cycle.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 start SHALL be ignored in SEND and DONE; the captured matrix SHALL NOT change mid-stream.
REQ-029 Elements outside m x n SHALL never be emitted.
REQ-030 With elemReady held high, exactly m*n elements SHALL be emitted in consecutive cycles, and done SHALL occur at T+1+m*n.
REQ-031 For a 1x1 matrix, the first element SHALL have both elemLast and rowLast set to 1.

Reset
REQ-032 On reset, the state SHALL be IDLE and row/col/m/n registers SHALL be 0.
REQ-033 On reset, all outputs (elemValid, elemData, elemRow, elemCol, elemLast, rowLast, busy, done, dimError) SHALL be 0.
REQ-034 Reset SHALL take priority over start and elemReady; reset during SEND SHALL abort the stream with no done pulse.

Configuration
REQ-035 When macro MATRIX_SER_TRANSPOSE_EN is defined, the block SHALL add input port transpose (1 bit).
REQ-036 With the macro defined, transpose SHALL be sampled with start; if 1, order SHALL be column-major: row increments, wraps at m-1 and then col increments.
REQ-037 With the macro defined and column-major order, rowLast SHALL mean row==m-1 (end of column).
REQ-038 With the macro defined, elemRow/elemCol SHALL always report true source indices.
REQ-039 Without the macro, the transpose port SHALL NOT exist and order SHALL be row-major only.

Verification
REQ-040 m=2, n=3, element (i,j)=10*i+j, elemReady=1 -> elemData 0,1,2,10,11,12 in cycles T+1..T+6; rowLast at 2 and 12; elemLast at 12; done at T+7.
REQ-041 m=5, n=5, elemReady toggling 1,0 -> 25 transfers; data stable during every stall; done one cycle after the 25th transfer.
REQ-042 start with m=0, n=3, then with m=6, n=2 -> one dimError pulse each; busy and elemValid stay 0.
REQ-043 m=3, n=3; reset asserted after the 4th transfer -> all outputs 0 next cycle; no done; new start with m=1, n=1 -> one element with elemLast=rowLast=1.
REQ-044 start pulsed again during SEND with a different matrix -> stream continues with the original data, unchanged.
REQ-045 (MATRIX_SER_TRANSPOSE_EN) m=2, n=3, transpose=1 -> data 0,10,1,11,2,12; rowLast on 10, 11 and 12; elemLast on 12.
